// File: rtl/fuzz_top_pkg.sv
// fuzz_top_pkg: shared constants and helpers for the fuzz_top datapath.
//   - Field offsets/widths of the 350-bit status word y.
//   - LFSR seed and Galois feedback mask.
//   - rotl17 / popcnt49 helper functions used by the top level.
package fuzz_top_pkg;

    localparam int IN_W = 49;
    localparam int Y_W  = 350;

    localparam int Y_IND1_LSB = 0;    localparam int Y_IND1_W = 49;
    localparam int Y_IND2_LSB = 49;   localparam int Y_IND2_W = 49;
    localparam int Y_SUM_LSB  = 98;   localparam int Y_SUM_W  = 18;
    localparam int Y_PROD_LSB = 116;  localparam int Y_PROD_W = 24;
    localparam int Y_XR_LSB   = 140;  localparam int Y_XR_W   = 17;
    localparam int Y_ROT_LSB  = 157;  localparam int Y_ROT_W  = 17;
    localparam int Y_ACC_LSB  = 174;  localparam int Y_ACC_W  = 32;
    localparam int Y_CNT_LSB  = 206;  localparam int Y_CNT_W  = 8;
    localparam int Y_CMP_LSB  = 214;
    localparam int Y_PAR_LSB  = 215;
    localparam int Y_LFSR_LSB = 216;  localparam int Y_LFSR_W = 64;
    localparam int Y_MAC_LSB  = 280;  localparam int Y_MAC_W  = 48;
    localparam int Y_POP_LSB  = 328;  localparam int Y_POP_W  = 6;
    localparam int Y_FOLD_LSB = 334;  localparam int Y_FOLD_W = 16;

    localparam logic [63:0] LFSR_SEED = 64'h1;
    localparam logic [63:0] LFSR_MASK = 64'hD800_0000_0000_0000;

    // Rotate left within 17 bits: the upper half of the doubled word
    // shifted left holds the wrapped-around result.
    function automatic logic [16:0] rotl17(input logic [16:0] x, input logic [3:0] amt);
        logic [33:0] t;
        t = {x, x} << amt;
        return t[33:17];
    endfunction

    function automatic logic [5:0] popcnt49(input logic [48:0] v);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < 49; i++) n = n + 6'(v[i]);
        return n;
    endfunction

endpackage

// File: rtl/fuzz_lfsr64.sv
// fuzz_lfsr64: 64-bit right-shifting Galois LFSR, advances every clock.
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset (loads LFSR_SEED)
//   state  out  current LFSR value
module fuzz_lfsr64
    import fuzz_top_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    output logic [63:0] state
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= LFSR_SEED;
        else        state <= (state >> 1) ^ (state[0] ? LFSR_MASK : 64'h0);
    end

endmodule

// File: rtl/fuzz_top.sv
// fuzz_top: registered mixed-function datapath publishing a 350-bit status word.
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   wire0  in   17-bit unsigned operand A
//   wire1  in   9-bit unsigned operand B
//   wire2  in   3-bit unsigned tag
//   wire3  in   14-bit signed operand C
//   wire4  in   6-bit control, [3:0] = rotate amount
//   y      out  packed result word (field map in fuzz_top_pkg)
module fuzz_top
    import fuzz_top_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic [16:0]    wire0,
    input  logic [8:0]     wire1,
    input  logic [2:0]     wire2,
    input  logic [13:0]    wire3,
    input  logic [5:0]     wire4,
    output logic [Y_W-1:0] y
);

    logic [IN_W-1:0]  in_c;
    logic signed [13:0] c_s;
    logic signed [9:0]  b_s;
    logic signed [23:0] prod_c;

    assign in_c   = {wire4, wire3, wire2, wire1, wire0};
    assign c_s    = wire3;
    assign b_s    = {1'b0, wire1};
    assign prod_c = 24'(b_s) * 24'(c_s);

    logic [IN_W-1:0]    in_p1, in_p2;
    logic [17:0]        sum_p1;
    logic signed [23:0] prod_p1;
    logic [16:0]        xr_p1, rot_p1;
    logic [31:0]        acc_p1;
    logic [7:0]         cnt_p1;
    logic               cmp_p1, par_p1;
    logic [63:0]        lfsr_p1;
    logic [47:0]        mac_p1;
    logic [5:0]         pop_p1;
    logic [15:0]        fold_p1;

    // Stage p1: every field registered from the current inputs / own state.
    // in_p2 and mac_p1 see one extra stage (in_p1 and prod_p1 before this edge).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_p1   <= '0;
            in_p2   <= '0;
            sum_p1  <= '0;
            prod_p1 <= '0;
            xr_p1   <= '0;
            rot_p1  <= '0;
            acc_p1  <= '0;
            cnt_p1  <= '0;
            cmp_p1  <= 1'b0;
            par_p1  <= 1'b0;
            mac_p1  <= '0;
            pop_p1  <= '0;
            fold_p1 <= '0;
        end else begin
            in_p1   <= in_c;
            in_p2   <= in_p1;
            sum_p1  <= 18'(wire0) + 18'(wire1);
            prod_p1 <= prod_c;
            xr_p1   <= wire0 ^ {wire3, wire2};
            rot_p1  <= rotl17(wire0, wire4[3:0]);
            acc_p1  <= acc_p1 + {{18{c_s[13]}}, c_s};
            cnt_p1  <= cnt_p1 + 8'd1;
            cmp_p1  <= wire0 > {wire1, 8'b0};
            par_p1  <= ^in_c;
            mac_p1  <= mac_p1 + {{24{prod_p1[23]}}, prod_p1};
            pop_p1  <= popcnt49(in_c);
            fold_p1 <= fold_p1 ^ wire0[15:0];
        end
    end

    fuzz_lfsr64 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .state (lfsr_p1)
    );

    assign y[Y_IND1_LSB +: Y_IND1_W] = in_p1;
    assign y[Y_IND2_LSB +: Y_IND2_W] = in_p2;
    assign y[Y_SUM_LSB  +: Y_SUM_W]  = sum_p1;
    assign y[Y_PROD_LSB +: Y_PROD_W] = prod_p1;
    assign y[Y_XR_LSB   +: Y_XR_W]   = xr_p1;
    assign y[Y_ROT_LSB  +: Y_ROT_W]  = rot_p1;
    assign y[Y_ACC_LSB  +: Y_ACC_W]  = acc_p1;
    assign y[Y_CNT_LSB  +: Y_CNT_W]  = cnt_p1;
    assign y[Y_CMP_LSB]              = cmp_p1;
    assign y[Y_PAR_LSB]              = par_p1;
    assign y[Y_LFSR_LSB +: Y_LFSR_W] = lfsr_p1;
    assign y[Y_MAC_LSB  +: Y_MAC_W]  = mac_p1;
    assign y[Y_POP_LSB  +: Y_POP_W]  = pop_p1;
    assign y[Y_FOLD_LSB +: Y_FOLD_W] = fold_p1;

endmodule

// File: tb/tb_fuzz_top.sv
module tb_fuzz_top;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [16:0]  wire0 = '0;
    logic [8:0]   wire1 = '0;
    logic [2:0]   wire2 = '0;
    logic [13:0]  wire3 = '0;
    logic [5:0]   wire4 = '0;
    logic [349:0] y;

    int errors = 0;
    int checks = 0;

    fuzz_top dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wire0 (wire0),
        .wire1 (wire1),
        .wire2 (wire2),
        .wire3 (wire3),
        .wire4 (wire4),
        .y     (y)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Reference model state, one variable per published field.
    logic [48:0] m_in1, m_in2;
    logic [17:0] m_sum;
    logic [23:0] m_prod;
    logic [16:0] m_xr, m_rot;
    logic [31:0] m_acc;
    logic [7:0]  m_cnt;
    logic        m_cmp, m_par;
    logic [63:0] m_lfsr;
    logic [47:0] m_mac;
    logic [5:0]  m_pop;
    logic [15:0] m_fold;

    task automatic model_reset();
        m_in1 = '0; m_in2 = '0; m_sum = '0; m_prod = '0; m_xr = '0; m_rot = '0;
        m_acc = '0; m_cnt = '0; m_cmp = 1'b0; m_par = 1'b0; m_lfsr = 64'h1;
        m_mac = '0; m_pop = '0; m_fold = '0;
    endtask

    task automatic model_edge();
        logic [48:0] inw;
        longint c, p, x;
        int r;
        inw = {wire4, wire3, wire2, wire1, wire0};
        c = longint'($signed(wire3));
        m_mac = m_mac + 48'(longint'($signed(m_prod)));
        p = longint'(wire1) * c;
        m_prod = p[23:0];
        m_sum = 18'(int'(wire0) + int'(wire1));
        m_xr = wire0 ^ {wire3, wire2};
        r = int'(wire4[3:0]);
        x = longint'(wire0);
        x = ((x << r) | (x >> (17 - r))) & 64'h1FFFF;
        m_rot = x[16:0];
        m_acc = m_acc + 32'(c);
        m_cnt = 8'((int'(m_cnt) + 1) % 256);
        m_cmp = int'(wire0) > int'(wire1) * 256;
        m_pop = 6'($countones(inw));
        m_par = m_pop[0];
        if (m_lfsr[0]) m_lfsr = (m_lfsr >> 1) ^ 64'hD800_0000_0000_0000;
        else           m_lfsr = m_lfsr >> 1;
        m_fold = m_fold ^ wire0[15:0];
        m_in2 = m_in1;
        m_in1 = inw;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".in_d1"}, 64'(y[48:0]),    64'(m_in1));
        chk({tag, ".in_d2"}, 64'(y[97:49]),   64'(m_in2));
        chk({tag, ".sum"},   64'(y[115:98]),  64'(m_sum));
        chk({tag, ".prod"},  64'(y[139:116]), 64'(m_prod));
        chk({tag, ".xr"},    64'(y[156:140]), 64'(m_xr));
        chk({tag, ".rot"},   64'(y[173:157]), 64'(m_rot));
        chk({tag, ".acc"},   64'(y[205:174]), 64'(m_acc));
        chk({tag, ".cnt"},   64'(y[213:206]), 64'(m_cnt));
        chk({tag, ".cmp"},   64'(y[214]),     64'(m_cmp));
        chk({tag, ".par"},   64'(y[215]),     64'(m_par));
        chk({tag, ".lfsr"},  y[279:216],      m_lfsr);
        chk({tag, ".mac"},   64'(y[327:280]), 64'(m_mac));
        chk({tag, ".pop"},   64'(y[333:328]), 64'(m_pop));
        chk({tag, ".fold"},  64'(y[349:334]), 64'(m_fold));
    endtask

    // Drive inputs, take one edge, advance the model, sample 1 time unit later.
    task automatic step(input logic [16:0] a, input logic [8:0] b, input logic [2:0] t,
                        input logic [13:0] c, input logic [5:0] ctl, input bit do_chk,
                        input string tag);
        wire0 = a; wire1 = b; wire2 = t; wire3 = c; wire4 = ctl;
        @(posedge clk);
        model_edge();
        #1;
        if (do_chk) check_all(tag);
    endtask

    // Asynchronous reset pulse placed mid-cycle, checked before any edge.
    task automatic mid_reset(input string tag);
        logic [349:0] rst_y;
        rst_y = '0;
        rst_y[279:216] = 64'h1;
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        chk({tag, ".word_lo"}, y[63:0], rst_y[63:0]);
        chk({tag, ".lfsr_hi"}, y[279:216], rst_y[279:216]);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        #1 rst_n = 1'b0;
        #1;
        check_all("reset");
        chk("reset.lfsr_const", y[279:216], 64'h1);
        chk("reset.mac_const", 64'(y[327:280]), 64'h0);
        #1 rst_n = 1'b1;

        // All-ones vector, first edge after reset.
        step(17'h1FFFF, 9'h1FF, 3'h7, 14'h3FFF, 6'h3F, 1'b1, "ones");
        chk("ones.sum",  64'(y[115:98]),  64'h201FE);
        chk("ones.prod", 64'(y[139:116]), 64'hFFFE01);
        chk("ones.xr",   64'(y[156:140]), 64'h0);
        chk("ones.rot",  64'(y[173:157]), 64'h1FFFF);
        chk("ones.acc",  64'(y[205:174]), 64'hFFFFFFFF);
        chk("ones.cnt",  64'(y[213:206]), 64'h1);
        chk("ones.cmp",  64'(y[214]),     64'h1);
        chk("ones.par",  64'(y[215]),     64'h1);
        chk("ones.pop",  64'(y[333:328]), 64'd49);
        chk("ones.fold", 64'(y[349:334]), 64'hFFFF);
        chk("ones.mac",  64'(y[327:280]), 64'h0);
        chk("ones.lfsr", y[279:216],      64'hD800_0000_0000_0000);

        step('0, '0, '0, '0, '0, 1'b1, "zeros");
        chk("zeros.mac",   64'(y[327:280]), 64'hFFFF_FFFF_FE01);
        chk("zeros.in_d2", 64'(y[97:49]),   64'h1_FFFF_FFFF_FFFF);
        chk("zeros.lfsr",  y[279:216],      64'h6C00_0000_0000_0000);

        step(17'h00001, '0, '0, '0, 6'h04, 1'b1, "rot4");
        chk("rot4.rot", 64'(y[173:157]), 64'h00010);
        step(17'h00001, '0, '0, '0, 6'h0F, 1'b1, "rot15");
        chk("rot15.rot", 64'(y[173:157]), 64'h08000);

        // Counter wrap and accumulator from a clean reset.
        mid_reset("rst2");
        for (int i = 0; i < 256; i++) step('0, '0, '0, '0, '0, 1'b0, "hold");
        check_all("hold256");
        chk("hold256.cnt", 64'(y[213:206]), 64'h0);
        chk("hold256.acc", 64'(y[205:174]), 64'h0);
        for (int i = 0; i < 3; i++) step('0, '0, '0, 14'h2000, '0, 1'b0, "neg");
        check_all("neg3");
        chk("neg3.acc", 64'(y[205:174]), 64'hFFFFA000);

        // Random vectors, async reset mid-stream, then more random vectors.
        for (int i = 0; i < 10; i++)
            step(17'($urandom), 9'($urandom), 3'($urandom), 14'($urandom), 6'($urandom),
                 1'b1, "rand_a");
        mid_reset("rst_mid");
        for (int i = 0; i < 30; i++)
            step(17'($urandom), 9'($urandom), 3'($urandom), 14'($urandom), 6'($urandom),
                 1'b1, "rand_b");
        // Boundary operands for compare: equal and just above.
        step(17'h1FF00, 9'h1FF, '0, 14'h2000, '0, 1'b1, "cmp_eq");
        chk("cmp_eq.cmp", 64'(y[214]), 64'h0);
        step(17'h1FF01, 9'h1FF, '0, 14'h1FFF, '0, 1'b1, "cmp_gt");
        chk("cmp_gt.cmp", 64'(y[214]), 64'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
